// File: rtl/gshare_pkg.sv
// Shared gshare types: 2-bit counter encoding, saturating update helpers, PHT index hash.
// Pure combinational helpers; no state, no flow control.
`timescale 1ns/1ps
package gshare_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_RESET = CTR_WNT;

  // Widest index the hash helper supports; callers size-cast down to PHT_IDX_W.
  localparam int unsigned IDX_MAX_W = 16;
  typedef logic [IDX_MAX_W-1:0] idx_max_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] imm_tgt;
    logic [31:0] pc_plus4;
  } pred_stage_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

  function automatic idx_max_t gshare_idx(input idx_max_t pc_bits, input idx_max_t ghr_bits);
    return pc_bits ^ ghr_bits;
  endfunction

endpackage

// File: rtl/gshare_btb.sv
// Direct-mapped branch target buffer: registered lookup (1 cycle), write on resolved taken branches.
// No backpressure; a write and a lookup of the same entry in one cycle returns the pre-write contents.
`timescale 1ns/1ps
module gshare_btb #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 27
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] i_lk_idx,
  input  logic [TAG_W-1:0] i_lk_tag,
  output logic             o_lk_hit,
  output logic [31:0]      o_lk_tgt,
  input  logic             i_wr_vld,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [31:0]      i_wr_tgt
);

  localparam int unsigned N = 1 << IDX_W;

  logic             r_vld [N];
  logic [TAG_W-1:0] r_tag [N];
  logic [31:0]      r_tgt [N];
  logic             r_hit;
  logic [31:0]      r_out_tgt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N); i++) r_vld[i] <= 1'b0;
      r_hit     <= 1'b0;
      r_out_tgt <= '0;
    end else begin
      r_hit     <= r_vld[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);
      r_out_tgt <= r_tgt[i_lk_idx];
      if (i_wr_vld) r_vld[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by r_vld, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (i_wr_vld) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      r_tgt[i_wr_idx] <= i_wr_tgt;
    end
  end

  assign o_lk_hit = r_hit;
  assign o_lk_tgt = r_out_tgt;

endmodule

// File: rtl/gshare_predictor_param.sv
// Gshare direction predictor with speculative GHR, checkpoint restore and registered redirect; 1-cycle predict.
// No backpressure: one predict and one resolve accepted every cycle. Optional BTB under GSHARE_BTB_EN.
`timescale 1ns/1ps
module gshare_predictor_param
  import gshare_pkg::*;
#(
  parameter int unsigned PHT_IDX_W = 5,
  parameter int unsigned GHR_W     = 5,
  parameter int unsigned PC_LSB    = 1,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  input  logic [31:0]      pred_imm_target_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [31:0]      pred_target_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             res_valid_i,
  input  logic [31:0]      res_pc_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  input  logic [GHR_W-1:0] res_ghr_i,
  input  logic             res_mispredict_i,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o
);

  localparam int unsigned PHT_N = 1 << PHT_IDX_W;

  ctr_t                 r_pht [PHT_N];
  logic [GHR_W-1:0]     r_ghr;
  pred_stage_t          r_stage;
  logic                 r_pred_vld;
  logic [GHR_W-1:0]     r_pred_ghr;
  logic                 r_redir_vld;
  logic [31:0]          r_redir_pc;

  logic [PHT_IDX_W-1:0] w_pred_idx;
  logic [PHT_IDX_W-1:0] w_res_idx;
  logic                 w_pred_taken;
  logic                 w_restore;
  logic [31:0]          w_taken_tgt;

  assign w_pred_idx = PHT_IDX_W'(gshare_idx(idx_max_t'(pred_pc_i[PC_LSB +: PHT_IDX_W]),
                                            idx_max_t'(r_ghr)));
  assign w_res_idx  = PHT_IDX_W'(gshare_idx(idx_max_t'(res_pc_i[PC_LSB +: PHT_IDX_W]),
                                            idx_max_t'(res_ghr_i)));

  // Read is taken from the array before this cycle's training write lands.
  assign w_pred_taken = r_pht[w_pred_idx][1];
  assign w_restore    = res_valid_i & res_mispredict_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(PHT_N); i++) r_pht[i] <= CTR_RESET;
    end else if (res_valid_i) begin
      r_pht[w_res_idx] <= res_taken_i ? sat_inc(r_pht[w_res_idx]) : sat_dec(r_pht[w_res_idx]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ghr <= '0;
    end else if (w_restore) begin
      r_ghr <= {res_ghr_i[GHR_W-2:0], res_taken_i};
    end else if (pred_valid_i) begin
      r_ghr <= {r_ghr[GHR_W-2:0], w_pred_taken};
    end
  end

  // A restore in the same cycle squashes the prediction made on the stale history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pred_vld <= 1'b0;
      r_stage    <= '0;
      r_pred_ghr <= '0;
    end else begin
      r_pred_vld <= pred_valid_i & ~w_restore;
      if (pred_valid_i) begin
        r_stage.taken    <= w_pred_taken;
        r_stage.imm_tgt  <= pred_imm_target_i;
        r_stage.pc_plus4 <= pred_pc_i + 32'd4;
        r_pred_ghr       <= r_ghr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      r_redir_vld <= w_restore;
      if (w_restore) r_redir_pc <= res_taken_i ? res_target_i : res_pc_i + 32'd4;
    end
  end

`ifdef GSHARE_BTB_EN
  localparam int unsigned TAG_W = 32 - PC_LSB - BTB_IDX_W;

  logic        w_btb_hit;
  logic [31:0] w_btb_tgt;

  gshare_btb #(
    .IDX_W (BTB_IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_lk_idx (pred_pc_i[PC_LSB +: BTB_IDX_W]),
    .i_lk_tag (pred_pc_i[31 -: TAG_W]),
    .o_lk_hit (w_btb_hit),
    .o_lk_tgt (w_btb_tgt),
    .i_wr_vld (res_valid_i & res_taken_i),
    .i_wr_idx (res_pc_i[PC_LSB +: BTB_IDX_W]),
    .i_wr_tag (res_pc_i[31 -: TAG_W]),
    .i_wr_tgt (res_target_i)
  );

  assign w_taken_tgt = w_btb_hit ? w_btb_tgt : r_stage.imm_tgt;
`else
  assign w_taken_tgt = r_stage.imm_tgt;
`endif

  assign pred_valid_o     = r_pred_vld;
  assign pred_taken_o     = r_stage.taken;
  assign pred_target_o    = r_stage.taken ? w_taken_tgt : r_stage.pc_plus4;
  assign pred_ghr_o       = r_pred_ghr;
  assign redirect_valid_o = r_redir_vld;
  assign redirect_pc_o    = r_redir_pc;

endmodule
